imem_responder: RTL and testbench

//   Instruction-memory responder on the fetch side of the single-cycle core. It accepts word

---
 rtl/imem_pkg.sv | 19 +
 rtl/imem_resp_fifo.sv | 66 ++++++
 rtl/imem_responder.sv | 112 +++++++++++
 tb/tb_imem_responder.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory responder.
package imem_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h00000013;

  // One fetch response: instruction word, echoed byte address, fault flag.
  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] addr;
    logic            fault;
  } resp_t;

  // Full word index of a byte address; upper bits beyond the RAM size mark a fault.
  function automatic logic [XLEN-3:0] word_idx(input logic [XLEN-1:0] addr);
    return addr[XLEN-1:2];
  endfunction

endpackage

// File: rtl/imem_resp_fifo.sv
// Small in-order response queue between the read stage and the consumer.
module imem_resp_fifo
  import imem_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  resp_t         push_data,
  input  logic          pop,
  output logic          valid,
  output resp_t         data,
  output logic [CW-1:0] count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  resp_t         entries_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Next pointer and occupancy values; simultaneous push and pop keep the count.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = next_ptr(wr_ptr_q);
    if (pop)  rd_ptr_d = next_ptr(rd_ptr_q);
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Control state clears on reset; any queued responses are dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage needs no reset because it is masked while the queue is empty.
  always_ff @(posedge clk) begin
    if (push) entries_q[wr_ptr_q] <= push_data;
  end

  assign valid = (count_q != '0);
  assign data  = valid ? entries_q[rd_ptr_q] : '0;
  assign count = count_q;

endmodule

// File: rtl/imem_responder.sv
// Fetch-side instruction memory: valid/ready requests in, in-order {instr, addr, fault} out.
module imem_responder
  import imem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int RESP_DEPTH  = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_instr,
  output logic [31:0] resp_addr,
  output logic        resp_fault,
  input  logic        ld_en,
  input  logic [31:0] ld_addr,
  input  logic [31:0] ld_data
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = $clog2(RESP_DEPTH + 1);

  logic [XLEN-1:0] mem [DEPTH_WORDS];
  logic [XLEN-1:0] rd_data_q;

  logic            acc;
  logic            pop;
  logic            req_fault;
  logic            ld_in_range;
  logic [AW-1:0]   req_idx;
  logic [CW:0]     occupancy;

  logic            s1_valid_q, s1_valid_d;
  logic            s1_fault_q, s1_fault_d;
  logic [XLEN-1:0] s1_addr_q,  s1_addr_d;

  resp_t           push_data;
  resp_t           fifo_data;
  logic            fifo_valid;
  logic [CW-1:0]   fifo_count;

  // Request decode: word index, fault classification and the credit check.
  always_comb begin
    req_idx     = req_addr[AW+1:2];
    req_fault   = (req_addr[1:0] != 2'b00) ||
                  ({2'b00, word_idx(req_addr)} >= XLEN'(DEPTH_WORDS));
    ld_in_range = (ld_addr < XLEN'(DEPTH_WORDS));
    pop         = fifo_valid & resp_ready;
    occupancy   = (CW+1)'(s1_valid_q) + (CW+1)'(fifo_count) - (CW+1)'(pop);
    req_ready   = !ld_en && (occupancy < (CW+1)'(RESP_DEPTH));
    acc         = req_valid & req_ready;
  end

  // Synchronous RAM: the read data register is loaded on accept, loads write the array.
  always_ff @(posedge clk) begin
    if (acc) rd_data_q <= mem[req_idx];
    if (ld_en && ld_in_range) mem[ld_addr[AW-1:0]] <= ld_data;
  end

  // S1 next state: capture address and fault alongside the RAM read.
  always_comb begin
    s1_valid_d = acc;
    s1_addr_d  = s1_addr_q;
    s1_fault_d = s1_fault_q;
    if (acc) begin
      s1_addr_d  = req_addr;
      s1_fault_d = req_fault;
    end
  end

  // S1 register; reset discards a fetch that is still waiting for its RAM data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_addr_q  <= '0;
      s1_fault_q <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_addr_q  <= s1_addr_d;
      s1_fault_q <= s1_fault_d;
    end
  end

  // Faulting fetches ignore the RAM word and return a NOP instead.
  always_comb begin
    push_data.instr = s1_fault_q ? NOP_INSTR : rd_data_q;
    push_data.addr  = s1_addr_q;
    push_data.fault = s1_fault_q;
  end

  imem_resp_fifo #(
    .DEPTH(RESP_DEPTH)
  ) u_resp_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (s1_valid_q),
    .push_data(push_data),
    .pop      (pop),
    .valid    (fifo_valid),
    .data     (fifo_data),
    .count    (fifo_count)
  );

  assign resp_valid = fifo_valid;
  assign resp_instr = fifo_data.instr;
  assign resp_addr  = fifo_data.addr;
  assign resp_fault = fifo_data.fault;

endmodule

// File: tb/tb_imem_responder.sv
// Self-checking bench for imem_responder: directed scenarios plus a randomized scoreboard run.
module tb_imem_responder;

  localparam int DEPTH_WORDS = 1024;
  localparam int RESP_DEPTH  = 2;
  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid, req_ready, resp_valid, resp_ready, resp_fault, ld_en;
  logic [31:0] req_addr, resp_instr, resp_addr, ld_addr, ld_data;

  int checks   = 0;
  int failures = 0;
  int win      = 0;

  logic [31:0] model_mem [DEPTH_WORDS];
  logic [31:0] a_val [4];

  typedef struct {
    logic [31:0] instr;
    logic [31:0] addr;
    logic        fault;
    int          win;
  } exp_t;

  always #5 clk = ~clk;

  imem_responder #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .RESP_DEPTH (RESP_DEPTH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_instr(resp_instr),
    .resp_addr (resp_addr),
    .resp_fault(resp_fault),
    .ld_en     (ld_en),
    .ld_addr   (ld_addr),
    .ld_data   (ld_data)
  );

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic expect_fault(input logic [31:0] a);
    return ((a % 32'd4) != 32'd0) || ((a / 32'd4) >= 32'(DEPTH_WORDS));
  endfunction

  function automatic logic [31:0] expect_instr(input logic [31:0] a);
    if (expect_fault(a)) return NOP;
    return model_mem[10'(a / 32'd4)];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    win++;
  endtask

  task automatic set_idle();
    req_valid  = 1'b0;
    req_addr   = '0;
    resp_ready = 1'b1;
    ld_en      = 1'b0;
    ld_addr    = '0;
    ld_data    = '0;
  endtask

  task automatic load_word(input logic [31:0] idx, input logic [31:0] data);
    req_valid = 1'b0;
    ld_en     = 1'b1;
    ld_addr   = idx;
    ld_data   = data;
    tick();
    ld_en = 1'b0;
    if (idx < 32'(DEPTH_WORDS)) model_mem[10'(idx)] = data;
  endtask

  task automatic fetch(input logic [31:0] a, output logic [31:0] instr,
                       output logic [31:0] raddr, output logic flt, output bit got);
    int n;
    got = 1'b0; instr = '0; raddr = '0; flt = 1'b0;
    req_valid = 1'b1; req_addr = a; resp_ready = 1'b1; ld_en = 1'b0;
    n = 0;
    #2;
    while (!req_ready && n < 20) begin tick(); #2; n++; end
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      #2;
      if (resp_valid) begin
        instr = resp_instr; raddr = resp_addr; flt = resp_fault; got = 1'b1;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    set_idle();
    #1 reset = 1'b1;
    #2;
    checks++; if (resp_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_resp_valid: got %0b want 0", resp_valid); end
    checks++; if ({resp_instr, resp_addr, resp_fault} !== 65'd0) begin failures++; $display("[TB] FAIL reset_resp_fields: got %h/%h/%0b want 0/0/0", resp_instr, resp_addr, resp_fault); end
    tick();
    reset = 1'b0;
    #2;
    checks++; if (req_ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_req_ready: got %0b want 1", req_ready); end
    tick();
  endtask

  task automatic load_all();
    a_val[0] = 32'hA0A0_0000; a_val[1] = 32'hA1A1_1111;
    a_val[2] = 32'hA2A2_2222; a_val[3] = 32'hA3A3_3333;
    for (int i = 0; i < DEPTH_WORDS; i++) load_word(32'(i), $urandom);
    for (int i = 0; i < 4; i++) load_word(32'(i), a_val[i]);
  endtask

  task automatic test_back_to_back();
    resp_ready = 1'b1;
    for (int c = 0; c < 7; c++) begin
      req_valid = (c < 4);
      req_addr  = (c < 4) ? 32'(4 * c) : 32'd0;
      #2;
      if (c < 4) begin
        checks++; if (req_ready !== 1'b1) begin failures++; $display("[TB] FAIL b2b_req_ready[%0d]: got %0b want 1", c, req_ready); end
      end
      if (c >= 2 && c < 6) begin
        checks++;
        if (resp_valid !== 1'b1 || resp_instr !== a_val[c-2] || resp_addr !== 32'(4 * (c - 2)) || resp_fault !== 1'b0) begin
          failures++;
          $display("[TB] FAIL b2b_resp[%0d]: got v=%0b %h @%h f=%0b want v=1 %h @%h f=0", c, resp_valid, resp_instr, resp_addr, resp_fault, a_val[c-2], 32'(4 * (c - 2)));
        end
      end else begin
        checks++; if (resp_valid !== 1'b0) begin failures++; $display("[TB] FAIL b2b_idle[%0d]: got %0b want 0", c, resp_valid); end
      end
      tick();
    end
    req_valid = 1'b0;
  endtask

  task automatic test_backpressure();
    int accepted;
    accepted = 0;
    resp_ready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      req_valid = 1'b1;
      req_addr  = 32'h8 + 32'(4 * c);
      #2;
      if (req_valid && req_ready) accepted++;
      if (c >= 2) begin
        checks++;
        if (resp_valid !== 1'b1 || resp_instr !== model_mem[2] || resp_addr !== 32'h8) begin
          failures++;
          $display("[TB] FAIL bp_stall_hold[%0d]: got v=%0b %h @%h want v=1 %h @8", c, resp_valid, resp_instr, resp_addr, model_mem[2]);
        end
      end
      tick();
    end
    checks++; if (accepted != RESP_DEPTH) begin failures++; $display("[TB] FAIL bp_accept_count: got %0d want %0d", accepted, RESP_DEPTH); end
    #2;
    checks++; if (req_ready !== 1'b0) begin failures++; $display("[TB] FAIL bp_full_ready: got %0b want 0", req_ready); end
    req_valid = 1'b0;
    resp_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 1'b1) begin failures++; $display("[TB] FAIL bp_ready_comb: got %0b want 1", req_ready); end
    checks++; if (resp_valid !== 1'b1 || resp_instr !== model_mem[2]) begin failures++; $display("[TB] FAIL bp_drain0: got v=%0b %h want v=1 %h", resp_valid, resp_instr, model_mem[2]); end
    tick();
    #2;
    checks++; if (resp_valid !== 1'b1 || resp_instr !== model_mem[3] || resp_addr !== 32'hC) begin failures++; $display("[TB] FAIL bp_drain1: got v=%0b %h @%h want v=1 %h @c", resp_valid, resp_instr, resp_addr, model_mem[3]); end
    tick();
    #2;
    checks++; if (resp_valid !== 1'b0) begin failures++; $display("[TB] FAIL bp_empty: got %0b want 0", resp_valid); end
    tick();
  endtask

  task automatic test_fault();
    logic [31:0] instr, raddr;
    logic flt;
    bit got;
    fetch(32'h6, instr, raddr, flt, got);
    checks++; if (!got || flt !== 1'b1 || instr !== NOP || raddr !== 32'h6) begin failures++; $display("[TB] FAIL fault_misaligned: got g=%0b f=%0b %h @%h want g=1 f=1 %h @6", got, flt, instr, raddr, NOP); end
    fetch(32'h1000, instr, raddr, flt, got);
    checks++; if (!got || flt !== 1'b1 || instr !== NOP || raddr !== 32'h1000) begin failures++; $display("[TB] FAIL fault_range: got g=%0b f=%0b %h @%h want g=1 f=1 %h @1000", got, flt, instr, raddr, NOP); end
    fetch(32'hFFC, instr, raddr, flt, got);
    checks++; if (!got || flt !== 1'b0 || instr !== model_mem[1023] || raddr !== 32'hFFC) begin failures++; $display("[TB] FAIL fault_last_word: got g=%0b f=%0b %h want g=1 f=0 %h", got, flt, instr, model_mem[1023]); end
  endtask

  task automatic test_load();
    logic [31:0] instr, raddr;
    logic flt;
    bit got;
    req_valid = 1'b1; req_addr = 32'h14; resp_ready = 1'b1;
    ld_en = 1'b1; ld_addr = 32'd5; ld_data = 32'hDEADBEEF;
    for (int c = 0; c < 2; c++) begin
      #2;
      checks++; if (req_ready !== 1'b0) begin failures++; $display("[TB] FAIL load_blocks_req[%0d]: got %0b want 0", c, req_ready); end
      tick();
    end
    ld_en = 1'b0; req_valid = 1'b0;
    model_mem[5] = 32'hDEADBEEF;
    for (int c = 0; c < 3; c++) begin
      #2;
      checks++; if (resp_valid !== 1'b0) begin failures++; $display("[TB] FAIL load_no_accept[%0d]: got %0b want 0", c, resp_valid); end
      tick();
    end
    load_word(32'd1029, 32'h12345678);
    fetch(32'h14, instr, raddr, flt, got);
    checks++; if (!got || instr !== 32'hDEADBEEF || flt !== 1'b0) begin failures++; $display("[TB] FAIL load_readback: got g=%0b %h f=%0b want g=1 deadbeef f=0", got, instr, flt); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] instr, raddr;
    logic flt;
    bit got;
    resp_ready = 1'b0; req_valid = 1'b1; req_addr = 32'h4;
    tick();
    req_addr = 32'h8;
    tick();
    req_valid = 1'b0;
    #2;
    checks++; if (resp_valid !== 1'b1) begin failures++; $display("[TB] FAIL rst_mid_pre: got %0b want 1", resp_valid); end
    reset = 1'b1;
    #1;
    checks++; if (resp_valid !== 1'b0 || resp_instr !== 32'd0) begin failures++; $display("[TB] FAIL rst_mid_async: got v=%0b %h want v=0 0", resp_valid, resp_instr); end
    tick();
    reset = 1'b0;
    resp_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #2;
      checks++; if (resp_valid !== 1'b0) begin failures++; $display("[TB] FAIL rst_mid_stale[%0d]: got %0b want 0", c, resp_valid); end
      tick();
    end
    fetch(32'h0, instr, raddr, flt, got);
    checks++; if (!got || instr !== a_val[0] || flt !== 1'b0) begin failures++; $display("[TB] FAIL rst_mid_refetch: got g=%0b %h want g=1 %h", got, instr, a_val[0]); end
  endtask

  task automatic test_random();
    exp_t q[$];
    exp_t e;
    logic [31:0] last_i, last_a;
    logic last_f;
    bit stalled, exp_valid, exp_pop, exp_ready;
    int r;
    stalled = 1'b0; last_i = '0; last_a = '0; last_f = 1'b0;
    for (int c = 0; c < 10000; c++) begin
      ld_en   = ($urandom_range(0, 99) < 3);
      ld_addr = 32'($urandom_range(0, 1099));
      ld_data = $urandom;
      req_valid = ($urandom_range(0, 99) < 60);
      r = $urandom_range(0, 9);
      if (r == 0)      req_addr = $urandom;
      else if (r == 1) req_addr = 32'(4 * $urandom_range(0, 1023)) | 32'($urandom_range(1, 3));
      else             req_addr = 32'(4 * $urandom_range(0, 1023));
      resp_ready = ($urandom_range(0, 99) < 70);
      #2;
      exp_valid = (q.size() > 0) && (q[0].win + 2 <= win);
      exp_pop   = exp_valid && resp_ready;
      exp_ready = !ld_en && ((q.size() - int'(exp_pop)) < RESP_DEPTH);
      checks++; if (resp_valid !== exp_valid) begin failures++; $display("[TB] FAIL rnd_resp_valid[%0d]: got %0b want %0b", c, resp_valid, exp_valid); end
      checks++; if (req_ready !== exp_ready) begin failures++; $display("[TB] FAIL rnd_req_ready[%0d]: got %0b want %0b", c, req_ready, exp_ready); end
      if (resp_valid && q.size() > 0) begin
        checks++;
        if (resp_instr !== q[0].instr || resp_addr !== q[0].addr || resp_fault !== q[0].fault) begin
          failures++;
          $display("[TB] FAIL rnd_payload[%0d]: got %h @%h f=%0b want %h @%h f=%0b", c, resp_instr, resp_addr, resp_fault, q[0].instr, q[0].addr, q[0].fault);
        end
      end
      if (stalled) begin
        checks++;
        if (resp_instr !== last_i || resp_addr !== last_a || resp_fault !== last_f) begin
          failures++;
          $display("[TB] FAIL rnd_stall_stable[%0d]: got %h @%h f=%0b want %h @%h f=%0b", c, resp_instr, resp_addr, resp_fault, last_i, last_a, last_f);
        end
      end
      stalled = resp_valid && !resp_ready;
      last_i = resp_instr; last_a = resp_addr; last_f = resp_fault;
      if (resp_valid && resp_ready && q.size() > 0) void'(q.pop_front());
      if (req_valid && req_ready) begin
        e.instr = expect_instr(req_addr);
        e.addr  = req_addr;
        e.fault = expect_fault(req_addr);
        e.win   = win;
        q.push_back(e);
      end
      if (ld_en && ld_addr < 32'(DEPTH_WORDS)) model_mem[10'(ld_addr)] = ld_data;
      tick();
    end
    req_valid = 1'b0; ld_en = 1'b0; resp_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      #2;
      if (resp_valid && q.size() > 0) begin
        checks++;
        if (resp_instr !== q[0].instr || resp_addr !== q[0].addr || resp_fault !== q[0].fault) begin
          failures++;
          $display("[TB] FAIL rnd_drain[%0d]: got %h @%h want %h @%h", c, resp_instr, resp_addr, q[0].instr, q[0].addr);
        end
        void'(q.pop_front());
      end
      tick();
    end
    #2;
    checks++; if (q.size() != 0 || resp_valid !== 1'b0) begin failures++; $display("[TB] FAIL rnd_final_empty: got left=%0d v=%0b want left=0 v=0", q.size(), resp_valid); end
    tick();
  endtask

  initial begin
    $display("[TB] imem_responder bench start");
    test_reset();
    load_all();
    test_back_to_back();
    test_backpressure();
    test_fault();
    test_load();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
